// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store requester: memory op codes,
// exception flag layout and the requester FSM encoding.
package lsu_pkg;

  // Store and load word share code 000; req_we disambiguates.
  typedef enum logic [2:0] {
    MEM_OP_WORD = 3'b000,
    MEM_OP_SH   = 3'b001,
    MEM_OP_SB   = 3'b010,
    MEM_OP_LH   = 3'b100,
    MEM_OP_LHU  = 3'b101,
    MEM_OP_LB   = 3'b110,
    MEM_OP_LBU  = 3'b111
  } mem_op_e;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_mem_req.sv
// MEM-stage load/store requester: holds one request stable across the BRAM
// read latency and returns a single response over a valid/ready handshake.
module lsu_mem_req
  import lsu_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_exc_o,
  output logic [31:0] resp_badvaddr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [2:0]  mem_op_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_adel_i,
  input  logic        mem_ades_i
);

  state_e           state;
  logic             we_q;
  mem_op_e          op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       exc_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      op_q    <= MEM_OP_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= EXC_NONE;
      cnt_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            op_q    <= mem_op_e'(req_op_i);
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (mem_adel_i || mem_ades_i) begin
            exc_q   <= {mem_ades_i, mem_adel_i};
            rdata_q <= '0;
            state   <= ST_RESP;
          end else if (we_q) begin
            exc_q   <= EXC_NONE;
            rdata_q <= '0;
            state   <= ST_RESP;
          end else begin
            exc_q <= EXC_NONE;
            cnt_q <= CNT_W'(RD_LAT - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Address and op stay latched so the wrapper's lane select is valid.
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (cnt_q == '0) begin
            rdata_q <= mem_rdata_i;
            state   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (flush_i || resp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state == ST_IDLE);
  assign resp_valid_o    = (state == ST_RESP);
  assign resp_rdata_o    = rdata_q;
  assign resp_exc_o      = exc_q;
  assign resp_badvaddr_o = addr_q;

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_op_o    = op_q;

  // NOTE: the write strobe is decoded from the state register rather than
  // registered itself, so a flush in ISSUE suppresses the write within the
  // same cycle and an asynchronous reset drops it immediately.
  assign mem_we_o = we_q && (state == ST_ISSUE) && !flush_i;

endmodule
